// File: rtl/ram_bytewide_dp.sv
// rtl/ram_bytewide_dp.sv - byte-writable single-clock SRAM, RW port 0 + read port 1, self-clear after reset
module ram_bytewide_dp #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int WRITE_FIRST = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN0,
    input  logic [DATA_W/8-1:0] WE0,
    input  logic [ADDR_W-1:0]   A0,
    input  logic [DATA_W-1:0]   Di0,
    output logic [DATA_W-1:0]   Do0,
    input  logic                EN1,
    input  logic [ADDR_W-1:0]   A1,
    output logic [DATA_W-1:0]   Do1,
    output logic                BUSY
);
    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range0, in_range1;
    logic [DATA_W-1:0] rd0, rd1, merged0;
    logic              user_we, clr_we, collision;
    logic [DATA_W-1:0] do0_next, do1_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    assign BUSY = (state_q == CLEAR);

    // Out-of-range addresses (non-power-of-two DEPTH) read as zero and never write.
    assign in_range0 = ({1'b0, A0} < DEPTH_W);
    assign in_range1 = ({1'b0, A1} < DEPTH_W);
    assign rd0       = in_range0 ? mem[A0] : '0;
    assign rd1       = in_range1 ? mem[A1] : '0;

    always_comb begin
        merged0 = rd0;
        for (int i = 0; i < NB; i++) begin
            if (WE0[i]) merged0[i*8 +: 8] = Di0[i*8 +: 8];
        end
    end

    assign clr_we    = (state_q == CLEAR) && !RST;
    assign user_we   = (state_q == READY) && !RST && EN0 && (|WE0) && in_range0;
    assign collision = EN0 && (|WE0) && in_range0 && EN1 && (A0 == A1);

    always_comb begin
        do0_next = '0;
        do1_next = '0;
        if (EN0 && in_range0) do0_next = (WRITE_FIRST != 0) ? merged0 : rd0;
        if (EN1) do1_next = (collision && WRITE_FIRST != 0) ? merged0 : rd1;
    end

    // Clear and user writes are mutually exclusive, so the array keeps one write port.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (user_we) begin
            for (int i = 0; i < NB; i++) begin
                if (WE0[i]) mem[A0][i*8 +: 8] <= Di0[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || state_q == CLEAR) begin
            Do0 <= '0;
            Do1 <= '0;
        end else begin
            Do0 <= do0_next;
            Do1 <= do1_next;
        end
    end
endmodule

// File: tb/tb_ram_bytewide_dp.sv
// tb/tb_ram_bytewide_dp.sv - directed bench for ram_bytewide_dp: read-first, write-first and DEPTH=24 instances
module tb_ram_bytewide_dp;
    logic        CLK;
    logic        RST;
    logic        EN0, EN1;
    logic [3:0]  WE0;
    logic [4:0]  A0, A1;
    logic [31:0] Di0;
    logic [31:0] do0_rf, do1_rf, do0_wf, do1_wf, do0_d24, do1_d24;
    logic        busy_rf, busy_wf, busy_d24;

    int total = 0;
    int bad   = 0;

    ram_bytewide_dp #(.DATA_W(32), .DEPTH(32), .WRITE_FIRST(0)) dut_rf (
        .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(do0_rf),
        .EN1(EN1), .A1(A1), .Do1(do1_rf), .BUSY(busy_rf)
    );
    ram_bytewide_dp #(.DATA_W(32), .DEPTH(32), .WRITE_FIRST(1)) dut_wf (
        .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(do0_wf),
        .EN1(EN1), .A1(A1), .Do1(do1_wf), .BUSY(busy_wf)
    );
    ram_bytewide_dp #(.DATA_W(32), .DEPTH(24), .WRITE_FIRST(0)) dut_d24 (
        .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(do0_d24),
        .EN1(EN1), .A1(A1), .Do1(do1_d24), .BUSY(busy_d24)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        EN0 = 1'b0; WE0 = 4'h0; A0 = '0; Di0 = '0;
        EN1 = 1'b0; A1 = '0;
    endtask

    initial begin
        int cnt_rf, cnt_wf, cnt_d24, cnt;
        logic all_zero;

        RST = 1'b1;
        idle();

        // 1. reset then clear
        step(); step(); step();
        check("rst_busy", 32'(busy_rf), 32'd1);
        check("rst_do0", do0_rf, 32'h0);
        RST = 1'b0;
        cnt_rf = -1; cnt_wf = -1; cnt_d24 = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (!busy_rf  && cnt_rf  < 0) cnt_rf  = c;
            if (!busy_wf  && cnt_wf  < 0) cnt_wf  = c;
            if (!busy_d24 && cnt_d24 < 0) cnt_d24 = c;
        end
        check("busy_len_rf", 32'(cnt_rf), 32'd32);
        check("busy_len_wf", 32'(cnt_wf), 32'd32);
        check("busy_len_d24", 32'(cnt_d24), 32'd24);
        all_zero = 1'b1;
        EN1 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a);
            step();
            if (do1_rf !== 32'h0 || do1_wf !== 32'h0) all_zero = 1'b0;
        end
        check("clear_all_zero", 32'(all_zero), 32'd1);
        idle();

        // 2. byte enables
        EN0 = 1'b1; WE0 = 4'b1111; A0 = 5'd5; Di0 = 32'hDEADBEEF;
        step();
        WE0 = 4'b0101; Di0 = 32'h11223344;
        step();
        check("be_rf_do0_old", do0_rf, 32'hDEADBEEF);
        check("be_wf_do0_merged", do0_wf, 32'hDE22BE44);
        idle();
        EN1 = 1'b1; A1 = 5'd5;
        step();
        check("be_rf_do1", do1_rf, 32'hDE22BE44);
        check("be_wf_do1", do1_wf, 32'hDE22BE44);
        check("be_rf_do0_idle", do0_rf, 32'h0);

        // 3/4. collision
        idle();
        EN0 = 1'b1; WE0 = 4'b1111; A0 = 5'd7; Di0 = 32'hAAAAAAAA;
        step();
        Di0 = 32'h55555555; EN1 = 1'b1; A1 = 5'd7;
        step();
        check("col_rf_do0", do0_rf, 32'hAAAAAAAA);
        check("col_rf_do1", do1_rf, 32'hAAAAAAAA);
        check("col_wf_do0", do0_wf, 32'h55555555);
        check("col_wf_do1", do1_wf, 32'h55555555);
        idle();
        EN1 = 1'b1; A1 = 5'd7;
        step();
        check("col_rf_after", do1_rf, 32'h55555555);
        check("col_wf_after", do1_wf, 32'h55555555);

        // 6. DEPTH=24 boundary
        idle();
        EN0 = 1'b1; WE0 = 4'b1111; A0 = 5'd23; Di0 = 32'hCAFEF00D;
        step();
        A0 = 5'd30; Di0 = 32'h12345678;
        step();
        check("d24_oor_wr_do0", do0_d24, 32'h0);
        WE0 = 4'h0; A0 = 5'd23; EN1 = 1'b1; A1 = 5'd30;
        step();
        check("d24_rd23", do0_d24, 32'hCAFEF00D);
        check("d24_rd30_p1", do1_d24, 32'h0);
        check("d32_rd30_p1", do1_rf, 32'h12345678);
        A0 = 5'd30; EN1 = 1'b0;
        step();
        check("d24_rd30_p0", do0_d24, 32'h0);
        check("d32_rd30_p0", do0_rf, 32'h12345678);
        check("d32_en1_off", do1_rf, 32'h0);
        EN0 = 1'b0;
        step();
        check("en0_off_do0", do0_rf, 32'h0);

        // 5. reset mid-clear
        idle();
        EN0 = 1'b1; WE0 = 4'b1111; A0 = 5'd9; Di0 = 32'hBADBAD00;
        step();
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check("midclr_busy", 32'(busy_rf), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        cnt = 0;
        while (busy_rf && cnt < 100) begin
            step();
            cnt++;
            if (cnt == 5) begin
                EN0 = 1'b1; WE0 = 4'b1111; A0 = 5'd2; Di0 = 32'hFFFFFFFF;
            end
            if (cnt == 10) check("midclr_do0_busy", do0_rf, 32'h0);
            if (!busy_rf) idle();
        end
        check("midclr_busy_len", 32'(cnt), 32'd32);
        idle();
        EN1 = 1'b1; A1 = 5'd9;
        step();
        check("midclr_ram9_rf", do1_rf, 32'h0);
        check("midclr_ram9_wf", do1_wf, 32'h0);
        A1 = 5'd2;
        step();
        check("busy_write_dropped", do1_rf, 32'h0);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
